// File: rtl/alu_share_pkg.sv
// Shared types and constants for the two-port ALU sharing controller.
// Optional ALU_SHARE_LOCK_EN adds a per-request Lock that holds ownership across ops.
package alu_share_pkg;

  localparam int DW = 16;
  localparam int FW = 4;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_O = 0;

  localparam logic [4:0] ADD16 = 5'b10100;
  localparam logic [4:0] ADC16 = 5'b10101;
  localparam logic [4:0] SUB16 = 5'b10110;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    SETTLE  = 2'd2,
    RESPOND = 2'd3
  } state_e;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request/response channel of one ALU requester; master is the requester, slave the controller.
// Req_Lock exists only when ALU_SHARE_LOCK_EN is defined.
interface alu_share_ctrl_if;
  import alu_share_pkg::*;

  logic          Req_Valid;
  logic          Req_Ready;
  logic [4:0]    Req_FunSel;
  logic [DW-1:0] Req_A;
  logic [DW-1:0] Req_B;
  logic          Req_WF;
`ifdef ALU_SHARE_LOCK_EN
  logic          Req_Lock;
`endif
  logic          Rsp_Valid;
  logic          Rsp_Ready;
  logic [DW-1:0] Rsp_Result;
  logic [FW-1:0] Rsp_Flags;

  modport master (
`ifdef ALU_SHARE_LOCK_EN
    output Req_Lock,
`endif
    output Req_Valid, Req_FunSel, Req_A, Req_B, Req_WF, Rsp_Ready,
    input  Req_Ready, Rsp_Valid, Rsp_Result, Rsp_Flags
  );

  modport slave (
`ifdef ALU_SHARE_LOCK_EN
    input  Req_Lock,
`endif
    input  Req_Valid, Req_FunSel, Req_A, Req_B, Req_WF, Rsp_Ready,
    output Req_Ready, Rsp_Valid, Rsp_Result, Rsp_Flags
  );

endinterface

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-input round-robin arbiter; the pointer flips to the other side when an op completes.
// With ALU_SHARE_LOCK_EN a locked completion keeps the grant with the same owner.
module rr_arb2 (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [1:0] req,
  input  logic       enable,
  input  logic       done,
  input  logic       owner,
`ifdef ALU_SHARE_LOCK_EN
  input  logic       lock,
`endif
  output logic [1:0] grant
);

  logic ptr_q;
  logic locked_q;

`ifdef ALU_SHARE_LOCK_EN
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ptr_q    <= 1'b0;
      locked_q <= 1'b0;
    end else if (done) begin
      locked_q <= lock;
      if (!lock) ptr_q <= ~owner;
    end
  end
`else
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)    ptr_q <= 1'b0;
    else if (done) ptr_q <= ~owner;
  end
  assign locked_q = 1'b0;
`endif

  // While locked only the previous owner may be granted, regardless of the pointer.
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (locked_q)          grant[owner]  = req[owner];
      else if (req[ptr_q])   grant[ptr_q]  = 1'b1;
      else if (req[~ptr_q])  grant[~ptr_q] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one 16-bit ALU between two requesters: IDLE -> ISSUE -> SETTLE -> RESPOND.
// Define ALU_SHARE_LOCK_EN to add Req_Lock ownership chaining (e.g. ADD -> ADC).
module alu_share_ctrl
  import alu_share_pkg::*;
(
  input  logic            Clock,
  input  logic            Reset,
  alu_share_ctrl_if.slave ch0,
  alu_share_ctrl_if.slave ch1,
  output logic [DW-1:0]   ALU_A,
  output logic [DW-1:0]   ALU_B,
  output logic [4:0]      ALU_FunSel,
  output logic            ALU_WF,
  input  logic [DW-1:0]   ALU_Out,
  input  logic [FW-1:0]   ALU_Flags,
  output logic            Busy
);

  state_e        state_q, state_d;
  logic          owner_q;
  logic [1:0]    req_vld;
  logic [1:0]    grant;
  logic          accept;
  logic          sel;
  logic          rsp_done;
  logic [4:0]    fs_p0;
  logic [DW-1:0] a_p0;
  logic [DW-1:0] b_p0;
  logic          wf_p0;
  logic [DW-1:0] result_p1;
  logic [FW-1:0] flags_p2;

  assign req_vld  = {ch1.Req_Valid, ch0.Req_Valid};
  assign accept   = |grant;
  assign sel      = grant[1];
  assign rsp_done = (state_q == RESPOND) && (owner_q ? ch1.Rsp_Ready : ch0.Rsp_Ready);

`ifdef ALU_SHARE_LOCK_EN
  logic lock_p0;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)      lock_p0 <= 1'b0;
    else if (accept) lock_p0 <= sel ? ch1.Req_Lock : ch0.Req_Lock;
  end
`endif

  rr_arb2 u_arb (
    .Clock  (Clock),
    .Reset  (Reset),
    .req    (req_vld),
    .enable (state_q == IDLE),
    .done   (rsp_done),
    .owner  (owner_q),
`ifdef ALU_SHARE_LOCK_EN
    .lock   (lock_p0),
`endif
    .grant  (grant)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = SETTLE;
      SETTLE:  state_d = RESPOND;
      RESPOND: if (rsp_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      owner_q   <= 1'b0;
      fs_p0     <= '0;
      a_p0      <= '0;
      b_p0      <= '0;
      wf_p0     <= 1'b0;
      result_p1 <= '0;
      flags_p2  <= '0;
    end else begin
      // p0: operands latched at accept, held on the ALU until the next accept
      if (accept) begin
        owner_q <= sel;
        fs_p0   <= sel ? ch1.Req_FunSel : ch0.Req_FunSel;
        a_p0    <= sel ? ch1.Req_A      : ch0.Req_A;
        b_p0    <= sel ? ch1.Req_B      : ch0.Req_B;
        wf_p0   <= sel ? ch1.Req_WF     : ch0.Req_WF;
      end
      // p1: combinational ALU result at the closing edge of ISSUE
      if (state_q == ISSUE) result_p1 <= ALU_Out;
      // p2: ALU flag register has absorbed the ISSUE edge by SETTLE
      if (state_q == SETTLE) flags_p2 <= ALU_Flags;
    end
  end

  always_comb begin
    ALU_A      = a_p0;
    ALU_B      = b_p0;
    ALU_FunSel = fs_p0;
    ALU_WF     = (state_q == ISSUE) && wf_p0;
    Busy       = (state_q != IDLE);
  end

  assign ch0.Req_Ready  = grant[0];
  assign ch1.Req_Ready  = grant[1];
  assign ch0.Rsp_Valid  = (state_q == RESPOND) && !owner_q;
  assign ch1.Rsp_Valid  = (state_q == RESPOND) &&  owner_q;
  assign ch0.Rsp_Result = result_p1;
  assign ch1.Rsp_Result = result_p1;
  assign ch0.Rsp_Flags  = flags_p2;
  assign ch1.Rsp_Flags  = flags_p2;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: ALU stub, transaction-level reference model, directed + random traffic.
// Lock scenario is compiled only with ALU_SHARE_LOCK_EN.
module tb_alu_share_ctrl;
  import alu_share_pkg::*;

`ifdef ALU_SHARE_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  alu_share_ctrl_if ch0();
  alu_share_ctrl_if ch1();

  logic [DW-1:0] ALU_A, ALU_B, ALU_Out;
  logic [4:0]    ALU_FunSel;
  logic          ALU_WF, Busy;
  logic [FW-1:0] ALU_Flags;

  alu_share_ctrl dut (
    .Clock(Clock), .Reset(Reset), .ch0(ch0), .ch1(ch1),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FunSel(ALU_FunSel), .ALU_WF(ALU_WF),
    .ALU_Out(ALU_Out), .ALU_Flags(ALU_Flags), .Busy(Busy)
  );

  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    rsp_ready = 2'b00;
  logic [1:0]    req_wf    = 2'b00;
  logic [1:0]    req_lock  = 2'b00;
  logic [4:0]    req_fs [2] = '{5'd0, 5'd0};
  logic [DW-1:0] req_a  [2] = '{16'd0, 16'd0};
  logic [DW-1:0] req_b  [2] = '{16'd0, 16'd0};

  assign ch0.Req_Valid  = req_valid[0];
  assign ch1.Req_Valid  = req_valid[1];
  assign ch0.Req_FunSel = req_fs[0];
  assign ch1.Req_FunSel = req_fs[1];
  assign ch0.Req_A      = req_a[0];
  assign ch1.Req_A      = req_a[1];
  assign ch0.Req_B      = req_b[0];
  assign ch1.Req_B      = req_b[1];
  assign ch0.Req_WF     = req_wf[0];
  assign ch1.Req_WF     = req_wf[1];
  assign ch0.Rsp_Ready  = rsp_ready[0];
  assign ch1.Rsp_Ready  = rsp_ready[1];
`ifdef ALU_SHARE_LOCK_EN
  assign ch0.Req_Lock   = req_lock[0];
  assign ch1.Req_Lock   = req_lock[1];
`endif

  wire [1:0] rdy  = {ch1.Req_Ready, ch0.Req_Ready};
  wire [1:0] rvld = {ch1.Rsp_Valid, ch0.Rsp_Valid};

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference ALU arithmetic; returns {result, Z, C, N, O}.
  function automatic logic [19:0] alu_calc(input logic [4:0] fs, input logic [15:0] a,
                                           input logic [15:0] b, input logic cin);
    logic [16:0] s;
    logic [15:0] r;
    logic        ov;
    case (fs)
      ADD16:   s = {1'b0, a} + {1'b0, b};
      ADC16:   s = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      SUB16:   s = {1'b0, a} - {1'b0, b};
      default: s = {1'b0, a & b};
    endcase
    r = s[15:0];
    if (fs == SUB16)                     ov = (a[15] != b[15]) && (r[15] != a[15]);
    else if (fs == ADD16 || fs == ADC16) ov = (a[15] == b[15]) && (r[15] != a[15]);
    else                                 ov = 1'b0;
    return {r, (r == 16'd0), s[16], r[15], ov};
  endfunction

  // ALU stub: combinational result, flag register written on WF at the rising edge.
  logic [FW-1:0] alu_flags_r = 4'd0;
  logic [19:0]   alu_now;
  always_comb alu_now = alu_calc(ALU_FunSel, ALU_A, ALU_B, alu_flags_r[FLAG_C]);
  assign ALU_Out   = alu_now[19:4];
  assign ALU_Flags = alu_flags_r;
  always @(posedge Clock) if (ALU_WF) alu_flags_r <= alu_now[3:0];

  // Transaction-level model of the controller.
  bit          mon_en = 0;
  int          cyc = 0;
  bit          in_flight = 0;
  int          acc_cyc = 0;
  bit          p_own = 0, p_wf = 0, p_lock = 0;
  logic [15:0] p_res = 16'd0, p_a = 16'd0;
  logic [3:0]  p_fl = 4'd0;
  logic [3:0]  m_flags = 4'd0;
  bit          m_ptr = 0, m_locked = 0, m_lock_own = 0;
  int          rdy1_cnt = 0;

  always @(negedge Clock) if (mon_en) begin
    int w;
    logic [1:0]  exp_rdy, exp_rv;
    logic [19:0] calc;
    cyc++;
    if (rdy[1]) rdy1_cnt++;
    check("busy", 32'(Busy), 32'(in_flight));
    w = -1;
    exp_rdy = 2'b00;
    if (!in_flight) begin
      if (m_locked) begin
        if (req_valid[m_lock_own]) w = int'(m_lock_own);
      end else if (req_valid[m_ptr])  w = int'(m_ptr);
      else if (req_valid[!m_ptr])     w = int'(!m_ptr);
      if (w >= 0) exp_rdy[w] = 1'b1;
    end
    check("req_ready", 32'(rdy), 32'(exp_rdy));
    check("alu_wf", 32'(ALU_WF), 32'(in_flight && (cyc - acc_cyc == 1) && p_wf));
    if (in_flight && (cyc - acc_cyc == 1)) check("alu_a_issue", 32'(ALU_A), 32'(p_a));
    exp_rv = 2'b00;
    if (in_flight && (cyc - acc_cyc >= 3)) exp_rv[p_own] = 1'b1;
    check("rsp_valid", 32'(rvld), 32'(exp_rv));
    if (exp_rv != 2'b00) begin
      check("rsp_result", 32'(p_own ? ch1.Rsp_Result : ch0.Rsp_Result), 32'(p_res));
      check("rsp_flags",  32'(p_own ? ch1.Rsp_Flags  : ch0.Rsp_Flags),  32'(p_fl));
      if (rsp_ready[p_own]) begin
        in_flight = 0;
        m_flags   = p_fl;
        if (p_lock) begin
          m_locked   = 1;
          m_lock_own = p_own;
        end else begin
          m_locked = 0;
          m_ptr    = !p_own;
        end
      end
    end else if (w >= 0) begin
      calc      = alu_calc(req_fs[w], req_a[w], req_b[w], m_flags[FLAG_C]);
      in_flight = 1;
      acc_cyc   = cyc;
      p_own     = w[0];
      p_wf      = req_wf[w];
      p_lock    = LOCK_EN && req_lock[w];
      p_a       = req_a[w];
      p_res     = calc[19:4];
      p_fl      = p_wf ? calc[3:0] : m_flags;
    end
  end

  task automatic model_clear();
    in_flight = 0;
    m_ptr     = 0;
    m_locked  = 0;
  endtask

  task automatic set_op(input int s, input logic [4:0] fs, input logic [15:0] a,
                        input logic [15:0] b, input logic wf, input logic lk);
    req_fs[s] = fs; req_a[s] = a; req_b[s] = b; req_wf[s] = wf; req_lock[s] = lk;
  endtask

  task automatic rand_op(input int s);
    logic [4:0] fs;
    case ($urandom_range(0, 2))
      0:       fs = ADD16;
      1:       fs = ADC16;
      default: fs = SUB16;
    endcase
    set_op(s, fs, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
           LOCK_EN && ($urandom_range(0, 3) == 0));
  endtask

  task automatic wait_accept(input int s);
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      if (rdy[s] && req_valid[s]) begin ok = 1; break; end
    end
    check("accept_seen", 32'(ok), 32'd1);
    @(posedge Clock); #1;
    req_valid[s] = 1'b0;
  endtask

  task automatic wait_rsp(input int s, output logic [15:0] res, output logic [3:0] fl,
                          output int lat);
    bit ok = 0;
    res = 16'd0; fl = 4'd0; lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      lat++;
      if (rvld[s] && rsp_ready[s]) begin
        ok  = 1;
        res = s ? ch1.Rsp_Result : ch0.Rsp_Result;
        fl  = s ? ch1.Rsp_Flags  : ch0.Rsp_Flags;
        break;
      end
    end
    check("rsp_seen", 32'(ok), 32'd1);
    @(posedge Clock); #1;
  endtask

  task automatic do_op(input int s, input logic [4:0] fs, input logic [15:0] a,
                       input logic [15:0] b, input logic wf, input logic lk,
                       output logic [15:0] res, output logic [3:0] fl, output int lat);
    set_op(s, fs, a, b, wf, lk);
    rsp_ready[s] = 1'b1;
    req_valid[s] = 1'b1;
    wait_accept(s);
    wait_rsp(s, res, fl, lat);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clock);
      if (!Busy) begin ok = 1; break; end
    end
    check("idle_seen", 32'(ok), 32'd1);
    @(posedge Clock); #1;
  endtask

  task automatic apply_reset();
    mon_en = 0;
    req_valid = 2'b00;
    Reset = 1'b0;
    @(posedge Clock); #1;
    Reset = 1'b1;
    model_clear();
    mon_en = 1;
  endtask

  logic [15:0] res;
  logic [3:0]  fl, exp_fl;
  int          lat, cnt, snap;
  bit          found;
  logic [1:0]  hs;
  int          exp_seq [4] = '{0, 1, 0, 1};

  initial begin
    repeat (2) @(posedge Clock);
    #1;
    check("rst_busy",   32'(Busy), 32'd0);
    check("rst_ready",  32'(rdy), 32'd0);
    check("rst_rspv",   32'(rvld), 32'd0);
    check("rst_alu_wf", 32'(ALU_WF), 32'd0);
    check("rst_alu_a",  32'(ALU_A), 32'd0);
    check("rst_alu_b",  32'(ALU_B), 32'd0);
    check("rst_alu_fs", 32'(ALU_FunSel), 32'd0);
    check("rst_result", 32'(ch0.Rsp_Result), 32'd0);
    check("rst_flags",  32'(ch1.Rsp_Flags), 32'd0);
    Reset = 1'b1;
    mon_en = 1;
    @(posedge Clock); #1;

    do_op(0, ADD16, 16'h0001, 16'h0002, 1'b1, 1'b0, res, fl, lat);
    check("add_result", 32'(res), 32'h0003);
    check("add_flags",  32'(fl), 32'h0);
    check("add_latency", 32'(lat), 32'd3);

    do_op(1, SUB16, 16'h0005, 16'h0005, 1'b1, 1'b0, res, fl, lat);
    check("sub_result", 32'(res), 32'h0000);
    check("sub_zflag",  32'(fl[FLAG_Z]), 32'd1);

    do_op(0, ADD16, 16'h0003, 16'h0004, 1'b0, 1'b0, res, fl, lat);
    check("nowf_result", 32'(res), 32'h0007);
    check("nowf_flags",  32'(fl), 32'h8);

    // both requesters valid continuously: strict alternation, 4 cycles per op
    apply_reset();
    rand_op(0); rand_op(1); req_lock = 2'b00;
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      found = 0; cnt = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge Clock);
        cnt++;
        if (|(rdy & req_valid)) begin found = 1; break; end
      end
      check("alt_found", 32'(found), 32'd1);
      check("alt_grant", 32'(rdy[1]), 32'(exp_seq[k]));
      if (k > 0) check("alt_spacing", 32'(cnt), 32'd4);
      @(posedge Clock); #1;
      if (k == 3) req_valid = 2'b00;
      else begin rand_op(int'(rdy[1])); req_lock = 2'b00; end
    end
    wait_idle();

    // response backpressure on requester 0
    set_op(0, ADD16, 16'h1234, 16'h1111, 1'b1, 1'b0);
    rsp_ready = 2'b10;
    req_valid[0] = 1'b1;
    wait_accept(0);
    rand_op(1); req_lock[1] = 1'b0;
    req_valid[1] = 1'b1;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      if (rvld[0]) begin found = 1; break; end
    end
    check("bp_rspv_seen", 32'(found), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      check("bp_rspv",   32'(rvld[0]), 32'd1);
      check("bp_result", 32'(ch0.Rsp_Result), 32'h2345);
      check("bp_flags",  32'(ch0.Rsp_Flags), 32'h0);
      check("bp_ready1", 32'(rdy[1]), 32'd0);
      check("bp_busy",   32'(Busy), 32'd1);
    end
    @(posedge Clock); #1;
    rsp_ready = 2'b11;
    wait_accept(1);
    wait_rsp(1, res, fl, lat);
    wait_idle();

    // reset while the op is in ISSUE
    set_op(0, ADD16, 16'hFFFF, 16'h0001, 1'b1, 1'b0);
    req_valid[0] = 1'b1;
    wait_accept(0);
    mon_en = 0;
    exp_fl = m_flags;
    Reset = 1'b0;
    #1;
    check("mid_rst_wf",    32'(ALU_WF), 32'd0);
    check("mid_rst_busy",  32'(Busy), 32'd0);
    check("mid_rst_rspv",  32'(rvld), 32'd0);
    check("mid_rst_alu_a", 32'(ALU_A), 32'd0);
    check("mid_rst_fs",    32'(ALU_FunSel), 32'd0);
    @(posedge Clock); #1;
    Reset = 1'b1;
    model_clear();
    mon_en = 1;
    set_op(0, ADD16, 16'h0003, 16'h0004, 1'b0, 1'b0);
    rand_op(1); req_lock[1] = 1'b0;
    req_valid = 2'b11;
    @(negedge Clock);
    check("post_rst_grant", 32'(rdy), 32'h1);
    @(posedge Clock); #1;
    req_valid = 2'b00;
    wait_rsp(0, res, fl, lat);
    check("post_rst_result", 32'(res), 32'h0007);
    check("post_rst_flags",  32'(fl), 32'(exp_fl));
    wait_idle();

`ifdef ALU_SHARE_LOCK_EN
    set_op(0, ADD16, 16'hFFFF, 16'h0001, 1'b1, 1'b1);
    req_valid[0] = 1'b1;
    wait_accept(0);
    snap = rdy1_cnt;
    set_op(1, SUB16, 16'h0009, 16'h0002, 1'b0, 1'b0);
    req_valid[1] = 1'b1;
    wait_rsp(0, res, fl, lat);
    check("lock_add_result", 32'(res), 32'h0000);
    check("lock_add_flags",  32'(fl), 32'hC);
    set_op(0, ADC16, 16'h0000, 16'h0000, 1'b1, 1'b0);
    req_valid[0] = 1'b1;
    wait_accept(0);
    wait_rsp(0, res, fl, lat);
    check("lock_adc_result", 32'(res), 32'h0001);
    check("lock_holdoff",    32'(rdy1_cnt - snap), 32'd0);
    wait_accept(1);
    wait_rsp(1, res, fl, lat);
    check("lock_req1_result", 32'(res), 32'h0007);
    wait_idle();
`endif

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge Clock);
      hs = rdy & req_valid;
      @(posedge Clock); #1;
      for (int s = 0; s < 2; s++) begin
        if (hs[s] || !req_valid[s]) begin
          if ($urandom_range(0, 1) == 1) begin rand_op(s); req_valid[s] = 1'b1; end
          else req_valid[s] = 1'b0;
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[s] = 1'b0;
        end
      end
      rsp_ready = 2'($urandom_range(0, 3));
    end
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
